// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: fetches one word per instruction over req/ack,
// hands it to decode over valid/ready, and applies jump/call/return redirects on the transfer cycle.
module pc_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir_data,
    output logic [15:0] ir_pc,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    input  logic        call_en,
    input  logic        ret_en,
    input  logic        halt,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int unsigned IW  = $clog2(STACK_DEPTH);
    localparam int unsigned SPW = IW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t         state;
    logic [15:0]    pc;
    logic [SPW-1:0] sp;
    logic [15:0]    stack [STACK_DEPTH];

    logic           transfer_c;
    logic           full_c;
    logic           empty_c;
    logic           do_ret_c;
    logic           do_call_c;
    logic           do_redir_c;
    logic [15:0]    link_c;
    logic [15:0]    ret_addr_c;

    // Redirect decode: only the transfer cycle counts, ret beats call beats jump.
    always_comb begin
        transfer_c = (state == HOLD) && ir_ready;
        full_c     = (sp == SPW'(STACK_DEPTH));
        empty_c    = (sp == '0);
        do_ret_c   = transfer_c && ret_en;
        do_call_c  = transfer_c && !ret_en && call_en;
        do_redir_c = transfer_c && !ret_en && !call_en && redirect_en;
        link_c     = ir_pc + 16'd1;
        ret_addr_c = stack[IW'(sp - SPW'(1))];
    end

    assign imem_addr = pc;

    // Return-address storage needs no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_call_c && !full_c) begin
            stack[sp[IW-1:0]] <= link_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            sp              <= '0;
            imem_req        <= 1'b0;
            ir_valid        <= 1'b0;
            ir_data         <= 16'h0000;
            ir_pc           <= 16'h0000;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir_data  <= imem_data;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + 16'd1;
                        imem_req <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (transfer_c) begin
                        ir_valid <= 1'b0;
                        if (halt) begin
                            state <= IDLE;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                    // An empty-stack return falls through to the next sequential word.
                    if (do_ret_c) begin
                        if (empty_c) begin
                            pc              <= link_c;
                            stack_underflow <= 1'b1;
                        end else begin
                            pc <= ret_addr_c;
                            sp <= sp - SPW'(1);
                        end
                    end else if (do_call_c) begin
                        pc <= redirect_pc;
                        if (full_c) begin
                            stack_overflow <= 1'b1;
                        end else begin
                            sp <= sp + SPW'(1);
                        end
                    end else if (do_redir_c) begin
                        pc <= redirect_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
